// File: rtl/spi_stream_out.sv
// Fabric-to-host byte stream: user logic fills a FIFO, the host drains it with one
// read command that returns a 16-bit length snapshot followed by that many bytes.
module spi_stream_out #(
    parameter logic [7:0]  CMD_READ      = 8'hE1,
    parameter int unsigned DEPTH_LOG2    = 9,
    parameter int unsigned IRQ_THRESHOLD = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          pw_wdata,
    input  logic                pw_wcmd,
    input  logic                pw_wstb,
    input  logic                pw_end,
    output logic                pw_req,
    input  logic                pw_gnt,
    output logic [7:0]          pw_rdata,
    input  logic                pw_rstb,
    output logic                pw_irq,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    output logic [DEPTH_LOG2:0] level
);
    localparam int unsigned      LVL_W = DEPTH_LOG2 + 1;
    localparam int unsigned      DEPTH = 1 << DEPTH_LOG2;
    localparam logic [LVL_W-1:0] FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] THR   = LVL_W'(IRQ_THRESHOLD);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_IGNORE = 3'd1;
    localparam logic [2:0] ST_LEN_LO = 3'd2;
    localparam logic [2:0] ST_LEN_HI = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_PAD    = 3'd5;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d, snap_q, snap_d, remain_q, remain_d;
    logic [2:0]            state_q, state_d;
    logic                  flush_pending_q, flush_pending_d;
    logic                  req_q, req_d, irq_q, irq_d, in_ready_q, in_ready_d;
    logic [7:0]            rdata_q, rdata_d;
    logic                  push, pop, accept, rstb_ok;
    logic [15:0]           snap16;

    always_comb begin
        state_d         = state_q;
        snap_d          = snap_q;
        remain_d        = remain_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        flush_pending_d = flush_pending_q;
        rdata_d         = 8'h00;
        rstb_ok         = pw_rstb && pw_gnt;
        push            = in_valid && in_ready_q;
        pop             = 1'b0;
        accept          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pw_wstb && pw_wcmd) begin
                    if (pw_wdata == CMD_READ) begin
                        accept   = 1'b1;
                        snap_d   = level_q;
                        remain_d = level_q;
                        state_d  = ST_LEN_LO;
                    end else begin
                        state_d = ST_IGNORE;
                    end
                end
            end
            ST_LEN_LO: if (rstb_ok) state_d = ST_LEN_HI;
            ST_LEN_HI: if (rstb_ok) state_d = (snap_q != '0) ? ST_DATA : ST_PAD;
            ST_DATA: begin
                if (rstb_ok) begin
                    pop      = 1'b1;
                    remain_d = remain_q - LVL_W'(1);
                    if (remain_q == LVL_W'(1)) state_d = ST_PAD;
                end
            end
            ST_IGNORE, ST_PAD: ;
            default: state_d = ST_IDLE;
        endcase

        // Host deselect aborts any transaction; unacknowledged bytes stay queued.
        if (pw_end && state_q != ST_IDLE) state_d = ST_IDLE;

        if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
        in_ready_d = (level_d != FULL);

        // A flush arriving with the snapshot survives for the next transaction.
        if (flush)       flush_pending_d = 1'b1;
        else if (accept) flush_pending_d = 1'b0;

        irq_d  = (state_d == ST_IDLE) &&
                 ((level_d >= THR) || (flush_pending_d && level_d != '0));
        req_d  = (state_d != ST_IDLE) && (state_d != ST_IGNORE);
        snap16 = 16'(snap_d);

        case (state_d)
            ST_LEN_LO: rdata_d = snap16[7:0];
            ST_LEN_HI: rdata_d = snap16[15:8];
            ST_DATA:   rdata_d = mem[rd_ptr_d];
            default:   rdata_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
            snap_q          <= '0;
            remain_q        <= '0;
            flush_pending_q <= 1'b0;
            req_q           <= 1'b0;
            irq_q           <= 1'b0;
            in_ready_q      <= 1'b1;
            rdata_q         <= 8'h00;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            level_q         <= level_d;
            snap_q          <= snap_d;
            remain_q        <= remain_d;
            flush_pending_q <= flush_pending_d;
            req_q           <= req_d;
            irq_q           <= irq_d;
            in_ready_q      <= in_ready_d;
            rdata_q         <= rdata_d;
        end
    end

    assign pw_req   = req_q;
    assign pw_irq   = irq_q;
    assign pw_rdata = rdata_q;
    assign in_ready = in_ready_q;
    assign level    = level_q;
endmodule

// File: tb/tb_spi_stream_out.sv
// Bench for spi_stream_out: a queue-based model of the FIFO and drain protocol,
// a vector table for level/irq/ready, hand-written corner sequences and random traffic.
module tb_spi_stream_out;
    localparam int DEPTH_LOG2 = 9;
    localparam int DEPTH      = 512;
    localparam int THR        = 256;

    logic                clk      = 1'b0;
    logic                rst      = 1'b1;
    logic [7:0]          pw_wdata = 8'h00;
    logic                pw_wcmd  = 1'b0;
    logic                pw_wstb  = 1'b0;
    logic                pw_end   = 1'b0;
    logic                pw_gnt   = 1'b0;
    logic                pw_rstb  = 1'b0;
    logic [7:0]          in_data  = 8'h00;
    logic                in_valid = 1'b0;
    logic                flush    = 1'b0;
    logic                pw_req, pw_irq, in_ready;
    logic [7:0]          pw_rdata;
    logic [DEPTH_LOG2:0] level;

    spi_stream_out #(
        .CMD_READ     (8'hE1),
        .DEPTH_LOG2   (DEPTH_LOG2),
        .IRQ_THRESHOLD(THR)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pw_wdata(pw_wdata),
        .pw_wcmd (pw_wcmd),
        .pw_wstb (pw_wstb),
        .pw_end  (pw_end),
        .pw_req  (pw_req),
        .pw_gnt  (pw_gnt),
        .pw_rdata(pw_rdata),
        .pw_rstb (pw_rstb),
        .pw_irq  (pw_irq),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .flush   (flush),
        .level   (level)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    byte unsigned mq[$];
    bit          fp = 1'b0;

    typedef struct {
        int n_push;
        bit do_flush;
        int exp_level;
        bit exp_irq;
        bit exp_ready;
    } irq_vec_t;

    irq_vec_t vec[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic bit irq_exp();
        return (mq.size() >= THR) || (fp && mq.size() != 0);
    endfunction

    task automatic do_reset();
        in_valid = 1'b0; flush = 1'b0; pw_wstb = 1'b0; pw_wcmd = 1'b0;
        pw_end = 1'b0; pw_gnt = 1'b0; pw_rstb = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        mq.delete();
        fp = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
        tick();
        in_valid = 1'b0;
        if (mq.size() != DEPTH) mq.push_back(b);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        fp    = 1'b1;
    endtask

    task automatic cmd(input logic [7:0] b);
        pw_wstb = 1'b1; pw_wcmd = 1'b1; pw_wdata = b;
        tick();
        pw_wstb = 1'b0; pw_wcmd = 1'b0; pw_wdata = 8'h00;
    endtask

    task automatic end_txn();
        pw_end = 1'b1;
        tick();
        pw_end = 1'b0;
        pw_gnt = 1'b0;
        chk("req_after_end", 32'(pw_req), 32'd0);
    endtask

    task automatic check_idle(input string nm);
        chk({nm, ".level"},    32'(level),    32'(mq.size()));
        chk({nm, ".in_ready"}, 32'(in_ready), 32'(mq.size() != DEPTH));
        chk({nm, ".irq"},      32'(pw_irq),   32'(irq_exp()));
        chk({nm, ".req"},      32'(pw_req),   32'd0);
    endtask

    // Expected stream: length low, length high, the snapped bytes in order, then zeros.
    task automatic drain(input int n_rstb, input bit rnd, input bit flush_with_cmd);
        int          snap;
        logic [15:0] s16;
        logic [7:0]  exp;
        snap  = mq.size();
        s16   = 16'(snap);
        flush = flush_with_cmd;
        cmd(8'hE1);
        flush = 1'b0;
        fp    = flush_with_cmd;
        chk("req_rise", 32'(pw_req), 32'd1);
        chk("irq_drop", 32'(pw_irq), 32'd0);
        pw_gnt = 1'b1;
        for (int i = 0; i < n_rstb; i++) begin
            if (rnd && $urandom_range(0, 4) == 0) begin
                pw_gnt = 1'b0; pw_rstb = 1'b1;
                tick();
                pw_rstb = 1'b0; pw_gnt = 1'b1;
                repeat (8) tick();
            end
            if (i == 0)              exp = s16[7:0];
            else if (i == 1)         exp = s16[15:8];
            else if (i - 2 < snap)   exp = mq[0];
            else                     exp = 8'h00;
            chk("drain_byte", 32'(pw_rdata), 32'(exp));
            pw_rstb = 1'b1;
            tick();
            pw_rstb = 1'b0;
            if (i >= 2 && i - 2 < snap) void'(mq.pop_front());
            for (int k = 0; k < 8; k++) begin
                if (rnd && $urandom_range(0, 3) == 0) push(8'($urandom));
                else tick();
            end
        end
        end_txn();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        vec[0] = '{0,   1'b0, 0,   1'b0, 1'b1};
        vec[1] = '{0,   1'b1, 0,   1'b0, 1'b1};
        vec[2] = '{10,  1'b0, 10,  1'b0, 1'b1};
        vec[3] = '{10,  1'b1, 10,  1'b1, 1'b1};
        vec[4] = '{255, 1'b0, 255, 1'b0, 1'b1};
        vec[5] = '{256, 1'b0, 256, 1'b1, 1'b1};
        vec[6] = '{511, 1'b0, 511, 1'b1, 1'b1};
        vec[7] = '{512, 1'b0, 512, 1'b1, 1'b0};

        // Outputs while reset is held
        tick();
        chk("rst.req",      32'(pw_req),   32'd0);
        chk("rst.rdata",    32'(pw_rdata), 32'd0);
        chk("rst.irq",      32'(pw_irq),   32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.level",    32'(level),    32'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 8; v++) begin
            do_reset();
            for (int i = 0; i < vec[v].n_push; i++) push(8'(i));
            if (vec[v].do_flush) do_flush();
            chk($sformatf("vec%0d.level", v), 32'(level),    32'(vec[v].exp_level));
            chk($sformatf("vec%0d.irq", v),   32'(pw_irq),   32'(vec[v].exp_irq));
            chk($sformatf("vec%0d.ready", v), 32'(in_ready), 32'(vec[v].exp_ready));
        end

        // 300-byte drain across the irq threshold
        do_reset();
        for (int i = 0; i < 255; i++) push(8'(i % 44));
        chk("A.irq_255", 32'(pw_irq), 32'd0);
        push(8'(255 % 44));
        chk("A.irq_256", 32'(pw_irq), 32'd1);
        for (int i = 256; i < 300; i++) push(8'(i % 44));
        check_idle("A.idle");
        drain(304, 1'b0, 1'b0);
        tick();
        chk("A.level_end", 32'(level), 32'd0);

        // Flush below threshold, then flush_pending cleared by the drain
        do_reset();
        for (int i = 0; i < 10; i++) push(8'(8'hA0 + i));
        chk("B.irq_before", 32'(pw_irq), 32'd0);
        do_flush();
        chk("B.irq_flush", 32'(pw_irq), 32'd1);
        drain(12, 1'b0, 1'b0);
        tick();
        check_idle("B.idle");
        push(8'h33);
        chk("B.no_irq_after", 32'(pw_irq), 32'd0);

        // Full FIFO: reject, then a held byte is accepted once a pop frees a slot
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(8'($urandom));
        chk("C.ready_full", 32'(in_ready), 32'd0);
        push(8'hEE);
        chk("C.level_full", 32'(level), 32'(DEPTH));
        in_valid = 1'b1;
        in_data  = 8'hAA;
        drain(3, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        mq.push_back(8'hAA);
        chk("C.level_held", 32'(level),    32'(DEPTH));
        chk("C.ready_held", 32'(in_ready), 32'd0);
        drain(DEPTH + 2, 1'b0, 1'b0);
        tick();
        check_idle("C.idle");

        // Foreign command: ignored until pw_end, FIFO untouched
        do_reset();
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
        cmd(8'h55);
        for (int i = 0; i < 3; i++) begin
            chk("D.req_low", 32'(pw_req), 32'd0);
            tick();
        end
        pw_gnt = 1'b1; pw_rstb = 1'b1;
        tick();
        pw_rstb = 1'b0;
        tick();
        chk("D.level", 32'(level), 32'd5);
        cmd(8'hE1);
        chk("D.req_e1_ignored", 32'(pw_req), 32'd0);
        pw_end = 1'b1;
        tick();
        pw_end = 1'b0; pw_gnt = 1'b0;
        tick();
        check_idle("D.idle");
        drain(9, 1'b0, 1'b0);

        // Early pw_end after 5 data bytes, next drain resumes at byte 6
        do_reset();
        for (int i = 0; i < 20; i++) push(8'(8'h10 + i));
        drain(7, 1'b0, 1'b0);
        tick();
        chk("E.level", 32'(level), 32'd15);
        drain(19, 1'b0, 1'b0);

        // Flush coincident with snapshot keeps flush_pending
        do_reset();
        for (int i = 0; i < 3; i++) push(8'(8'hC0 + i));
        drain(7, 1'b0, 1'b1);
        tick();
        check_idle("G.idle");
        push(8'h01);
        chk("G.irq_kept", 32'(pw_irq), 32'd1);

        // Asynchronous reset in DATA
        do_reset();
        for (int i = 0; i < 20; i++) push(8'(i));
        cmd(8'hE1);
        pw_gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pw_rstb = 1'b1;
            tick();
            pw_rstb = 1'b0;
            repeat (8) tick();
        end
        #2 rst = 1'b1;
        #1;
        chk("F.req",      32'(pw_req),   32'd0);
        chk("F.level",    32'(level),    32'd0);
        chk("F.in_ready", 32'(in_ready), 32'd1);
        chk("F.rdata",    32'(pw_rdata), 32'd0);
        chk("F.irq",      32'(pw_irq),   32'd0);
        tick();
        rst = 1'b0; pw_gnt = 1'b0;
        mq.delete();
        fp = 1'b0;
        tick();
        check_idle("F.idle");
        drain(4, 1'b0, 1'b0);

        // Random traffic against the model
        do_reset();
        for (int it = 0; it < 25; it++) begin
            int n;
            n = $urandom_range(0, 40);
            for (int i = 0; i < n; i++) push(8'($urandom));
            if ($urandom_range(0, 3) == 0) do_flush();
            tick();
            check_idle("R.pre");
            drain($urandom_range(0, mq.size() + 4), 1'b1, $urandom_range(0, 5) == 0);
            tick();
            check_idle("R.post");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_stream_out.md
# spi_stream_out

FPGA-to-host streaming endpoint on the badge SPI protocol bus (the `pw_*` side of `spi_dev_proto`). User logic pushes bytes into an internal FIFO. The block raises an interrupt when enough data is waiting, and the ESP32 drains the FIFO with a single read command. It is the outbound counterpart of the file-read stream: data flows from fabric to host instead of host to fabric.

## Interface
- `CMD_READ`, 8'hE1: command byte that opens a drain transaction.
- `DEPTH_LOG2`, 9: FIFO depth is 2^DEPTH_LOG2 bytes; range 4..15.
- `IRQ_THRESHOLD`, 256: FIFO level at or above which `pw_irq` asserts; range 1..2^DEPTH_LOG2.
- `clk` in 1: single clock domain.
- `rst` in 1: asynchronous reset, active-high.
- `pw_wdata` in 8: received SPI byte.
- `pw_wcmd` in 1: qualifies `pw_wstb`; high on the first byte after CS fall.
- `pw_wstb` in 1: one-cycle strobe, `pw_wdata` valid.
- `pw_end` in 1: one-cycle pulse on CS rise; the transaction ends.
- `pw_req` out 1: request ownership of the MISO byte stream.
- `pw_gnt` in 1: ownership granted, `pw_rdata` is being sampled.
- `pw_rdata` out 8: next byte to shift out.
- `pw_rstb` in 1: one-cycle pulse; the current `pw_rdata` byte has been consumed.
- `pw_irq` out 1: data-ready interrupt, active-high.
- `in_data` in 8: byte to enqueue.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: FIFO not full.
- `flush` in 1: one-cycle pulse; request an interrupt even if the level is below threshold.
- `level` out DEPTH_LOG2+1: current FIFO occupancy.

## Operation
- Reset values: `pw_req`=0, `pw_rdata`=8'h00, `pw_irq`=0, `in_ready`=1, `level`=0. FIFO is empty, `flush_pending`=0, FSM is in IDLE.
- Push: when `in_valid && in_ready`, write `in_data`. `in_ready` = (level != 2^DEPTH_LOG2).
- Push and pop in the same cycle: the level is unchanged, and both operations take effect.
- `flush` sets `flush_pending`. Snapshot time is the cycle the command is accepted (see IDLE).
  - `flush` alone: `flush_pending` is cleared at snapshot time.
  - `flush` coincident with a snapshot: the flush wins and `flush_pending` stays set.
- `pw_irq` = (level >= IRQ_THRESHOLD) || (flush_pending && level != 0), gated low while FSM != IDLE.
- FSM states and transitions:
  - IDLE: on `pw_wstb && pw_wcmd` with `pw_wdata == CMD_READ`, latch `snap = level` and go to LEN_LO. On any other command byte, go to IGNORE.
  - IGNORE: wait for `pw_end`, then return to IDLE. Never asserts `pw_req`.
  - LEN_LO: `pw_req`=1, `pw_rdata` = snap[7:0]. On `pw_rstb`, go to LEN_HI.
  - LEN_HI: `pw_rdata` = snap zero-extended to 16 bits, bits [15:8]. On `pw_rstb`, go to DATA if snap != 0, else PAD.
  - DATA: `pw_rdata` = FIFO head. On `pw_rstb`, pop one byte and decrement a remaining counter initialised to snap. Go to PAD when the counter reaches 0.
  - PAD: `pw_rdata` = 8'h00. `pw_rstb` is ignored.
- `pw_end` in any state except IDLE returns the FSM to IDLE and deasserts `pw_req` the next cycle. Bytes not yet consumed remain in the FIFO; only bytes acknowledged by `pw_rstb` are popped.
- Bytes pushed after the snapshot are not sent in the current transaction.
- New command strobes are ignored unless the FSM is in IDLE.
- `pw_rstb` without `pw_gnt` is ignored.

## Timing
- `pw_req` rises 1 cycle after the accepting command strobe. `pw_rdata` holds the LEN_LO byte from that same cycle.
- After each `pw_rstb`, `pw_rdata` is valid within 2 cycles; a registered BRAM read is permitted. `pw_rstb` pulses are at least 8 cycles apart.
- `level` is registered and updates 1 cycle after a push or pop.
- `in_ready` is registered and falls in the cycle the last free slot is written.
- `pw_irq` is registered: 1 cycle after its condition changes. It drops 1 cycle after the command is accepted.
- Asserting `rst` mid-transaction: all outputs return to reset values immediately (asynchronous) and the FIFO contents are discarded.

## Test plan
- Push 300 bytes (0x00..0x2B wrapping). Expect `pw_irq`=1 once `level` reaches 256. Send CMD 0xE1 and 304 `pw_rstb` pulses. Expect bytes 0x2C, 0x01, then the 300 payload bytes in order, then 0x00 0x00, then `level`=0.
- Push 10 bytes with no irq, then pulse `flush`. Expect `pw_irq`=1 after 1 cycle. Drain. Expect length bytes 0x0A, 0x00 and `flush_pending` cleared.
- Fill the FIFO to 512 bytes. Expect `in_ready`=0 and the 513th byte rejected. Pop one byte during a drain with `in_valid` held. Expect the held byte accepted and `level` staying 512.
- Command 0x55. Expect `pw_req` to stay 0 until `pw_end`, and the FIFO untouched.
- Drain with snap=20 and `pw_end` after 5 data bytes. Expect `level`=15 and the next drain to start at byte 6.
- Assert `rst` during the DATA state. Expect `pw_req`=0, `level`=0, `in_ready`=1 and the FSM in IDLE.
